// File: rtl/reg8_reader.sv
// reg8_reader: read-side sequencer for an NREG x W register file.
// A single start pulse sweeps the read select over registers 0..NREG-1 and
// emits each byte as a valid/ready beat. A final beat carries the XOR
// checksum of all bytes (dlast=1), then done pulses for one cycle.
//
// Ports:
//   clk     rising-edge clock
//   clr     asynchronous active-low reset
//   start   one-cycle sweep request (ignored while busy)
//   abort   synchronous cancel of a sweep in progress
//   q       register file read data (combinational from rsel)
//   rsel    register file read select
//   dout    stream data
//   dvalid  stream valid
//   dready  stream ready from the consumer
//   dlast   marks the checksum beat
//   busy    high in every state except IDLE
//   done    one-cycle pulse after the checksum beat is accepted
module reg8_reader #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int W    = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  q,
    output logic [AW-1:0] rsel,
    output logic [W-1:0]  dout,
    output logic          dvalid,
    input  logic          dready,
    output logic          dlast,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [W-1:0]  csum_q, csum_d;
    logic [W-1:0]  dout_q, dout_d;

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_ADDR;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            S_ADDR: begin
                // Capture the byte once; dout then holds through any stall.
                dout_d  = q;
                csum_d  = csum_q ^ q;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (dready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_CSUM;
                    end else begin
                        // idx only moves on entry to ADDR, keeping rsel stable
                        // across the ADDR/SEND span.
                        idx_d   = idx_q + AW'(1);
                        state_d = S_ADDR;
                    end
                end
            end
            S_CSUM: begin
                if (dready) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // abort overrides any progress; a beat accepted this cycle still counts
        // for the consumer, but the sweep ends here.
        if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    // Outputs
    always_comb begin
        rsel   = idx_q;
        dout   = (state_q == S_CSUM) ? csum_q : dout_q;
        dvalid = (state_q == S_SEND) || (state_q == S_CSUM);
        dlast  = (state_q == S_CSUM);
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_reg8_reader.sv
module tb_reg8_reader;

    logic       clk = 1'b0;
    logic       clr, start, abort, dready;
    logic [7:0] q;
    logic [2:0] rsel;
    logic [7:0] dout;
    logic       dvalid, dlast, busy, done;

    logic [7:0] regs [8];
    assign q = regs[rsel];

    reg8_reader #(.NREG(8), .AW(3), .W(8)) dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort), .q(q),
        .rsel(rsel), .dout(dout), .dvalid(dvalid), .dready(dready),
        .dlast(dlast), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       dready;
        logic [2:0] rsel;
        logic [7:0] dout;
        logic       dvalid;
        logic       dlast;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vt [22];

    function automatic vec_t mk(input logic dr, input logic [2:0] rs, input logic [7:0] d,
                                input logic v, input logic l, input logic b, input logic dn);
        vec_t r;
        r.dready = dr; r.rsel = rs; r.dout = d;
        r.dvalid = v;  r.dlast = l; r.busy = b; r.done = dn;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] rs, input logic dchk,
                             input logic [7:0] d, input logic v, input logic l,
                             input logic b, input logic dn);
        chk({tag, " rsel"}, 8'(rsel), 8'(rs));
        if (dchk) chk({tag, " dout"}, dout, d);
        chk({tag, " dvalid"}, 8'(dvalid), 8'(v));
        chk({tag, " dlast"}, 8'(dlast), 8'(l));
        chk({tag, " busy"}, 8'(busy), 8'(b));
        chk({tag, " done"}, 8'(done), 8'(dn));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full sweep with dready=1; start optionally re-pulsed in cycle restart_cyc.
    // Cycle c is the clock period following edge c-1 (start sampled at edge 0).
    task automatic run_sweep(input string tag, input logic [7:0] exp_csum, input int restart_cyc);
        int k;
        start  = 1'b1;
        dready = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            start = (c == restart_cyc);
            @(negedge clk);
            if (c <= 16) begin
                k = (c - 1) / 2;
                if (c % 2 == 0)
                    check_all($sformatf("%s c%0d", tag, c), 3'(k), 1'b1, regs[k], 1'b1, 1'b0, 1'b1, 1'b0);
                else
                    check_all($sformatf("%s c%0d", tag, c), 3'(k), 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            end else if (c == 17) begin
                check_all($sformatf("%s csum", tag), 3'd7, 1'b1, exp_csum, 1'b1, 1'b1, 1'b1, 1'b0);
            end else if (c == 18) begin
                check_all($sformatf("%s done", tag), 3'd7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
            end else begin
                check_all($sformatf("%s idle", tag), 3'd7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Stall run: dready low for 3 cycles in beat 3 (cycles 6..8).
        vt[0]  = mk(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[1]  = mk(1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[2]  = mk(1'b1, 3'd1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[3]  = mk(1'b1, 3'd1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[4]  = mk(1'b1, 3'd2, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[5]  = mk(1'b0, 3'd2, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[6]  = mk(1'b0, 3'd2, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[7]  = mk(1'b0, 3'd2, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[8]  = mk(1'b1, 3'd2, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[9]  = mk(1'b1, 3'd3, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[10] = mk(1'b1, 3'd3, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[11] = mk(1'b1, 3'd4, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[12] = mk(1'b1, 3'd4, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[13] = mk(1'b1, 3'd5, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[14] = mk(1'b1, 3'd5, 8'h06, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[15] = mk(1'b1, 3'd6, 8'h06, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[16] = mk(1'b1, 3'd6, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[17] = mk(1'b1, 3'd7, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[18] = mk(1'b1, 3'd7, 8'h08, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[19] = mk(1'b1, 3'd7, 8'h08, 1'b1, 1'b1, 1'b1, 1'b0);
        vt[20] = mk(1'b1, 3'd7, 8'h08, 1'b0, 1'b0, 1'b1, 1'b1);
        vt[21] = mk(1'b1, 3'd7, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) regs[i] = 8'(i + 1);
        clr = 1'b0; start = 1'b0; abort = 1'b0; dready = 1'b0;
        #2;
        check_all("reset", 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #21 clr = 1'b1;
        next_cycle();
        check_all("post-reset", 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Table-driven stall sweep; done lands in cycle 21.
        start  = 1'b1;
        dready = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 22; i++) begin
            dready = vt[i].dready;
            @(negedge clk);
            check_all($sformatf("stall c%0d", i + 1), vt[i].rsel, 1'b1, vt[i].dout,
                      vt[i].dvalid, vt[i].dlast, vt[i].busy, vt[i].done);
            next_cycle();
        end

        // Plain sweep with a start re-pulse during the SEND of beat 4 (cycle 8).
        run_sweep("busy-start", 8'h08, 8);

        // Abort in the SEND of beat 5 (cycle 10).
        start  = 1'b1;
        dready = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c < 10; c++) next_cycle();
        abort  = 1'b1;
        dready = 1'b0;
        @(negedge clk);
        check_all("abort at", 3'd4, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        abort = 1'b0;
        for (int c = 11; c <= 14; c++) begin
            @(negedge clk);
            check_all($sformatf("aborted c%0d", c), 3'd4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        run_sweep("restart", 8'h08, 0);

        // Asynchronous clear between clock edges mid-sweep.
        start  = 1'b1;
        dready = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c < 5; c++) next_cycle();
        #2 clr = 1'b0;
        #1;
        check_all("clr async", 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 clr = 1'b1;
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_all($sformatf("post-clr c%0d", c), 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end

        // start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        next_cycle();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check_all("start+abort idle", 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();

        // All-FF data: checksum cancels to 00.
        for (int i = 0; i < 8; i++) regs[i] = 8'hFF;
        run_sweep("all-ff", 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
